// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: writeback stage with its own MEM/WB pipeline register.
//
// Holds one instruction bundle from the MEM stage. A non-load retires in the
// cycle after it is accepted. A load retires in the cycle its split-transaction
// response (data_ok) arrives, and the response data is aligned and extended
// combinationally on the way to the register file. A flush kills the held
// instruction. If that instruction is a load whose response has not yet
// arrived, the stage remembers to discard that stale response.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   REG_AW register index width
//   CNT_W  retire counter width
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid / in_ready          MEM bundle handshake
//   in_pc, in_alu_result         PC and ALU result (load address for loads)
//   in_load_op                   one-hot LB,LH,LW,LBU,LHU,LWU,LD
//   in_res_from_mem              result comes from load data
//   in_gr_we, in_dest            GPR write enable and destination
//   data_ok, data_rdata          load response (one pulse per load, in order)
//   flush                        kill the held instruction
//   rf_we, rf_waddr, rf_wdata    register file write port
//   fwd_valid/dest/pending       forwarding and interlock hints
//   retire_cnt                   retired-instruction counter (wraps)
//   debug_wb_*                   trace port mirroring the write port
module wb_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_alu_result,
  input  logic [6:0]          in_load_op,
  input  logic                in_res_from_mem,
  input  logic                in_gr_we,
  input  logic [REG_AW-1:0]   in_dest,
  input  logic                data_ok,
  input  logic [XLEN-1:0]     data_rdata,
  input  logic                flush,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                fwd_valid,
  output logic [REG_AW-1:0]   fwd_dest,
  output logic                fwd_pending,
  output logic [CNT_W-1:0]    retire_cnt,
  output logic [XLEN-1:0]     debug_wb_pc,
  output logic [XLEN/8-1:0]   debug_wb_rf_we,
  output logic [REG_AW-1:0]   debug_wb_rf_wnum,
  output logic [XLEN-1:0]     debug_wb_rf_wdata
);

  localparam int OFFW = $clog2(XLEN/8);

  // Held bundle and control state
  logic                valid_r;
  logic                drop_r;
  logic [XLEN-1:0]     pc_r;
  logic [XLEN-1:0]     alu_r;
  logic [6:0]          load_op_r;
  logic                res_from_mem_r;
  logic                gr_we_r;
  logic [REG_AW-1:0]   dest_r;
  logic [CNT_W-1:0]    cnt_r;

  logic                ready_go;
  logic                accept;
  logic                retire;
  logic                dest_nz;
  logic [XLEN-1:0]     load_data;

  // Handshake
  assign ready_go = ~res_from_mem_r | data_ok;
  assign in_ready = ~rst & ~drop_r & ~flush & (~valid_r | ready_go);
  assign accept   = in_valid & in_ready;
  // rst gating keeps the write port quiet during the reset cycle itself
  assign retire   = valid_r & ready_go & ~flush & ~rst;
  assign dest_nz  = (dest_r != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r        <= 1'b0;
      drop_r         <= 1'b0;
      pc_r           <= '0;
      alu_r          <= '0;
      load_op_r      <= '0;
      res_from_mem_r <= 1'b0;
      gr_we_r        <= 1'b0;
      dest_r         <= '0;
      cnt_r          <= '0;
    end else begin
      if (accept) begin
        pc_r           <= in_pc;
        alu_r          <= in_alu_result;
        load_op_r      <= in_load_op;
        res_from_mem_r <= in_res_from_mem;
        gr_we_r        <= in_gr_we;
        dest_r         <= in_dest;
      end

      if (flush) begin
        valid_r <= 1'b0;
      end else if (accept) begin
        valid_r <= 1'b1;
      end else if (valid_r && ready_go) begin
        valid_r <= 1'b0;
      end

      // A flushed load whose response is still outstanding leaves one
      // response in flight; drop_r swallows it. A response arriving in the
      // same cycle as the flush is consumed right there.
      if (drop_r && data_ok) begin
        drop_r <= 1'b0;
      end else if (flush && valid_r && res_from_mem_r && !data_ok) begin
        drop_r <= 1'b1;
      end

      if (retire) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Load alignment and extension
  logic [OFFW-1:0] off;
  logic [7:0]      b_sel;
  logic [15:0]     h_sel;
  logic [31:0]     w_sel;
  logic            half_ok;
  logic            word_ok;

  assign off     = alu_r[OFFW-1:0];
  assign b_sel   = data_rdata[{off, 3'b000} +: 8];
  assign h_sel   = data_rdata[{off[OFFW-1:1], 4'b0000} +: 16];
  assign half_ok = ~off[0];
  assign word_ok = (off[1:0] == 2'b00);

  generate
    if (XLEN == 64) begin : g_word64
      assign w_sel = off[2] ? data_rdata[63:32] : data_rdata[31:0];
    end else begin : g_word32
      assign w_sel = data_rdata[31:0];
    end
  endgenerate

  always_comb begin
    load_data = '0;
    if (load_op_r[0]) begin
      load_data = XLEN'($signed(b_sel));
    end else if (load_op_r[1]) begin
      if (half_ok) load_data = XLEN'($signed(h_sel));
    end else if (load_op_r[2]) begin
      if (word_ok) load_data = XLEN'($signed(w_sel));
    end else if (load_op_r[3]) begin
      load_data = XLEN'(b_sel);
    end else if (load_op_r[4]) begin
      if (half_ok) load_data = XLEN'(h_sel);
    end else if (load_op_r[5]) begin
      // With XLEN=32 zero- and sign-extension of a word coincide
      if (word_ok) load_data = XLEN'(w_sel);
    end else if (load_op_r[6]) begin
      if (XLEN == 64) begin
        load_data = data_rdata;
      end else if (word_ok) begin
        load_data = XLEN'($signed(w_sel));
      end
    end
  end

  // Write port, forwarding hints and trace
  assign rf_we    = retire & gr_we_r & dest_nz;
  assign rf_waddr = dest_r;
  assign rf_wdata = res_from_mem_r ? load_data : alu_r;

  assign fwd_valid   = valid_r & gr_we_r & dest_nz;
  assign fwd_pending = fwd_valid & res_from_mem_r;
  assign fwd_dest    = dest_r;

  assign retire_cnt = cnt_r;

  assign debug_wb_pc       = pc_r;
  assign debug_wb_rf_we    = {(XLEN/8){rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed testbench for wb_stage_pipe. Two instances (XLEN=32 and XLEN=64)
// share one stimulus stream. The 32-bit instance sees the low halves of the
// wide data inputs.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] pc;
  logic [63:0] alu;
  logic [6:0]  load_op;
  logic        rfm;
  logic        gr_we;
  logic [4:0]  dest;
  logic        data_ok;
  logic [63:0] rdata;
  logic        flush;

  logic        in_ready32, rf_we32, fwd_valid32, fwd_pending32;
  logic [4:0]  rf_waddr32, fwd_dest32, dbg_wnum32;
  logic [31:0] rf_wdata32, dbg_pc32, dbg_wdata32;
  logic [3:0]  dbg_we32;
  logic [63:0] cnt32;

  logic        in_ready64, rf_we64, fwd_valid64, fwd_pending64;
  logic [4:0]  rf_waddr64, fwd_dest64, dbg_wnum64;
  logic [63:0] rf_wdata64, dbg_pc64, dbg_wdata64;
  logic [7:0]  dbg_we64;
  logic [63:0] cnt64;

  int          n_cmp;
  int          n_err;
  logic [63:0] exp_cnt;

  always #5 clk = ~clk;

  wb_stage_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(64)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_pc(pc[31:0]), .in_alu_result(alu[31:0]), .in_load_op(load_op),
    .in_res_from_mem(rfm), .in_gr_we(gr_we), .in_dest(dest),
    .data_ok(data_ok), .data_rdata(rdata[31:0]), .flush(flush),
    .rf_we(rf_we32), .rf_waddr(rf_waddr32), .rf_wdata(rf_wdata32),
    .fwd_valid(fwd_valid32), .fwd_dest(fwd_dest32), .fwd_pending(fwd_pending32),
    .retire_cnt(cnt32), .debug_wb_pc(dbg_pc32), .debug_wb_rf_we(dbg_we32),
    .debug_wb_rf_wnum(dbg_wnum32), .debug_wb_rf_wdata(dbg_wdata32)
  );

  wb_stage_pipe #(.XLEN(64), .REG_AW(5), .CNT_W(64)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_pc(pc), .in_alu_result(alu), .in_load_op(load_op),
    .in_res_from_mem(rfm), .in_gr_we(gr_we), .in_dest(dest),
    .data_ok(data_ok), .data_rdata(rdata), .flush(flush),
    .rf_we(rf_we64), .rf_waddr(rf_waddr64), .rf_wdata(rf_wdata64),
    .fwd_valid(fwd_valid64), .fwd_dest(fwd_dest64), .fwd_pending(fwd_pending64),
    .retire_cnt(cnt64), .debug_wb_pc(dbg_pc64), .debug_wb_rf_we(dbg_we64),
    .debug_wb_rf_wnum(dbg_wnum64), .debug_wb_rf_wdata(dbg_wdata64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one bundle for a single cycle (it is accepted at the next edge)
  task automatic issue(input logic [6:0] op, input logic from_mem, input logic we,
                       input logic [4:0] d, input logic [63:0] pcv, input logic [63:0] aluv);
    @(negedge clk);
    in_valid = 1'b1; load_op = op; rfm = from_mem; gr_we = we; dest = d;
    pc = pcv; alu = aluv; data_ok = 1'b0; flush = 1'b0;
    #1;
    chk("issue_ready", {63'd0, in_ready32}, 64'd1);
  endtask

  // Issue a load, wait some cycles, then raise data_ok; returns mid-cycle
  task automatic load(input logic [6:0] op, input logic [4:0] d, input logic [63:0] aluv,
                      input int waits, input logic [63:0] rdv);
    issue(op, 1'b1, 1'b1, d, 64'h200, aluv);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("wait_ready", {63'd0, in_ready32}, 64'd0);
      chk("wait_pending", {63'd0, fwd_pending32}, 64'd1);
      chk("wait_we", {63'd0, rf_we32}, 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; data_ok = 1'b1; rdata = rdv;
    #1;
  endtask

  task automatic resp_done;
    @(negedge clk);
    data_ok = 1'b0;
    exp_cnt = exp_cnt + 64'd1;
    #1;
    chk("load_cnt", cnt32, exp_cnt);
    chk("load_cnt64", cnt64, exp_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0; exp_cnt = 64'd0;
    rst = 1'b1; in_valid = 1'b0; pc = '0; alu = '0; load_op = '0; rfm = 1'b0;
    gr_we = 1'b0; dest = '0; data_ok = 1'b0; rdata = '0; flush = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_we", {63'd0, rf_we32}, 64'd0);
    chk("rst_wdata", {32'd0, rf_wdata32}, 64'd0);
    chk("rst_cnt", cnt32, 64'd0);
    chk("rst_fwd", {63'd0, fwd_valid32}, 64'd0);
    chk("rst_pc", {32'd0, dbg_pc32}, 64'd0);
    chk("rst_ready", {63'd0, in_ready32}, 64'd1);

    // ALU instruction: one-cycle latency
    issue(7'd0, 1'b0, 1'b1, 5'd5, 64'h100, 64'h1234);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("add_we", {63'd0, rf_we32}, 64'd1);
    chk("add_waddr", {59'd0, rf_waddr32}, 64'd5);
    chk("add_wdata", {32'd0, rf_wdata32}, 64'h1234);
    chk("add_wdata64", rf_wdata64, 64'h1234);
    chk("add_pc", {32'd0, dbg_pc32}, 64'h100);
    chk("add_dbg_we", {60'd0, dbg_we32}, 64'hF);
    chk("add_fwd", {63'd0, fwd_valid32}, 64'd1);
    chk("add_ready", {63'd0, in_ready32}, 64'd1);
    exp_cnt = 64'd1;
    @(negedge clk);
    #1;
    chk("add_cnt", cnt32, exp_cnt);
    chk("idle_we", {63'd0, rf_we32}, 64'd0);

    // LB offset 3, response two cycles later
    load(7'b0000001, 5'd6, 64'h1003, 2, 64'h0000_0000_80FF_0000);
    chk("lb_we", {63'd0, rf_we32}, 64'd1);
    chk("lb_wdata", {32'd0, rf_wdata32}, 64'hFFFF_FF80);
    chk("lb_wdata64", rf_wdata64, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_ready", {63'd0, in_ready32}, 64'd1);
    resp_done();

    // LBU same case
    load(7'b0001000, 5'd6, 64'h1003, 2, 64'h0000_0000_80FF_0000);
    chk("lbu_wdata", {32'd0, rf_wdata32}, 64'h0000_0080);
    chk("lbu_wdata64", rf_wdata64, 64'h80);
    resp_done();

    // LH offset 2
    load(7'b0000010, 5'd7, 64'h1002, 0, 64'h0000_0000_80FF_0000);
    chk("lh_wdata", {32'd0, rf_wdata32}, 64'hFFFF_80FF);
    chk("lh_wdata64", rf_wdata64, 64'hFFFF_FFFF_FFFF_80FF);
    resp_done();

    // LWU offset 4 (XLEN=32 sees offset 0 and behaves as LW)
    load(7'b0100000, 5'd8, 64'h2004, 1, 64'h8000_0001_1234_5678);
    chk("lwu_wdata64", rf_wdata64, 64'h0000_0000_8000_0001);
    chk("lwu_wdata32", {32'd0, rf_wdata32}, 64'h1234_5678);
    resp_done();

    // LW offset 4
    load(7'b0000100, 5'd8, 64'h2004, 0, 64'h8000_0001_1234_5678);
    chk("lw_wdata64", rf_wdata64, 64'hFFFF_FFFF_8000_0001);
    chk("lw_wdata32", {32'd0, rf_wdata32}, 64'h1234_5678);
    resp_done();

    // LH offset 1: misaligned -> 0
    load(7'b0000010, 5'd8, 64'h2001, 0, 64'h8000_0001_1234_5678);
    chk("lh_odd64", rf_wdata64, 64'd0);
    chk("lh_odd32", {32'd0, rf_wdata32}, 64'd0);
    resp_done();

    // LW offset 2: misaligned -> 0
    load(7'b0000100, 5'd8, 64'h2002, 0, 64'h8000_0001_1234_5678);
    chk("lw_mis64", rf_wdata64, 64'd0);
    chk("lw_mis32", {32'd0, rf_wdata32}, 64'd0);
    resp_done();

    // LD: full data on 64, LW on 32
    load(7'b1000000, 5'd9, 64'h2000, 0, 64'h8000_0001_1234_5678);
    chk("ld_wdata64", rf_wdata64, 64'h8000_0001_1234_5678);
    chk("ld_wdata32", {32'd0, rf_wdata32}, 64'h1234_5678);
    resp_done();

    // Flush while a load is waiting: stale response must be dropped
    issue(7'b0000001, 1'b1, 1'b1, 5'd7, 64'h300, 64'h0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    #1;
    chk("fl_we", {63'd0, rf_we32}, 64'd0);
    chk("fl_ready", {63'd0, in_ready32}, 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; load_op = '0; rfm = 1'b0; gr_we = 1'b1;
    dest = 5'd8; pc = 64'h304; alu = 64'h55;
    #1;
    chk("drop_ready", {63'd0, in_ready32}, 64'd0);
    chk("drop_fwd", {63'd0, fwd_valid32}, 64'd0);
    @(negedge clk);
    data_ok = 1'b1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("stale_we", {63'd0, rf_we32}, 64'd0);
    chk("stale_ready", {63'd0, in_ready32}, 64'd0);
    @(negedge clk);
    data_ok = 1'b0;
    #1;
    chk("stale_cnt", cnt32, exp_cnt);
    chk("post_drop_ready", {63'd0, in_ready32}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_drop_we", {63'd0, rf_we32}, 64'd1);
    chk("post_drop_waddr", {59'd0, rf_waddr32}, 64'd8);
    chk("post_drop_wdata", {32'd0, rf_wdata32}, 64'h55);
    exp_cnt = exp_cnt + 64'd1;
    @(negedge clk);
    #1;
    chk("post_drop_cnt", cnt32, exp_cnt);

    // Flush coincident with data_ok
    issue(7'b0000001, 1'b1, 1'b1, 5'd9, 64'h400, 64'h0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1; data_ok = 1'b1; rdata = 64'h7F;
    #1;
    chk("flok_we", {63'd0, rf_we32}, 64'd0);
    @(negedge clk);
    flush = 1'b0; data_ok = 1'b0;
    #1;
    chk("flok_ready", {63'd0, in_ready32}, 64'd1);
    chk("flok_cnt", cnt32, exp_cnt);
    chk("flok_fwd", {63'd0, fwd_valid32}, 64'd0);

    // dest = 0 with gr_we = 1
    issue(7'd0, 1'b0, 1'b1, 5'd0, 64'h500, 64'h77);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("d0_we", {63'd0, rf_we32}, 64'd0);
    chk("d0_fwd", {63'd0, fwd_valid32}, 64'd0);
    exp_cnt = exp_cnt + 64'd1;
    @(negedge clk);
    #1;
    chk("d0_cnt", cnt32, exp_cnt);

    // Reset mid-load; a later data_ok is ignored
    issue(7'b0000100, 1'b1, 1'b1, 5'd10, 64'h600, 64'h0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst2_in_ready", {63'd0, in_ready32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_cnt = 64'd0;
    chk("rst2_we", {63'd0, rf_we32}, 64'd0);
    chk("rst2_waddr", {59'd0, rf_waddr32}, 64'd0);
    chk("rst2_wdata", {32'd0, rf_wdata32}, 64'd0);
    chk("rst2_cnt", cnt32, exp_cnt);
    chk("rst2_pending", {63'd0, fwd_pending32}, 64'd0);
    chk("rst2_pc", {32'd0, dbg_pc32}, 64'd0);
    chk("rst2_dbg_we", {60'd0, dbg_we32}, 64'd0);
    @(negedge clk);
    data_ok = 1'b1; rdata = 64'h1234;
    #1;
    chk("rst2_stray_we", {63'd0, rf_we32}, 64'd0);
    chk("rst2_stray_ready", {63'd0, in_ready32}, 64'd1);
    @(negedge clk);
    data_ok = 1'b0;
    #1;
    chk("rst2_stray_cnt", cnt32, exp_cnt);
    chk("rst2_stray_cnt64", cnt64, exp_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
